// File: rtl/fc_trainer.sv
// fc_trainer: sequences one fc layer through accept, forward, capture, backward and result handshake per sample
module fc_trainer #(
   parameter int N = 9,
   parameter int FD_CYCLES = 100,
   parameter int BK_CYCLES = 100,
   parameter int OSC_HALF = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   input  logic [N-1:0]           sample_x,
   input  logic [N-1:0]           sample_target,
   output logic                   fd_prop,
   output logic                   bk_prop,
   output logic [N-1:0]           fin,
   output logic [N-1:0]           bin,
   input  logic [N-1:0]           fout,
   output logic                   oscillator,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [N-1:0]           result_out,
   output logic [$clog2(N+1)-1:0] result_errors
);
   localparam int CW = $clog2((FD_CYCLES > BK_CYCLES ? FD_CYCLES : BK_CYCLES) + 1);
   localparam int EW = $clog2(N + 1);
   localparam int OW = $clog2(OSC_HALF + 1);
   typedef enum logic [2:0] {IDLE, FWD, CAPTURE, BWD, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [OW-1:0] osc_cnt;
   logic [N-1:0] target, err, err_c;
   logic [EW-1:0] pc;
   assign sample_ready = state == IDLE && !rst_in;
   assign err_c = fout ^ target;
   always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) pc = pc + EW'(err_c[i]);
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt - CW'(1);
      case (state)
         IDLE: if (sample_valid) begin
            state_n = FWD;
            cnt_n = CW'(FD_CYCLES - 1);
         end
         FWD: state_n = cnt == '0 ? CAPTURE : FWD;
         CAPTURE: begin
            state_n = pc == '0 ? DONE : BWD;
            cnt_n = CW'(BK_CYCLES - 1);
         end
         BWD: state_n = cnt == '0 ? DONE : BWD;
         DONE: state_n = result_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         cnt <= '0;
         fin <= '0;
         target <= '0;
         err <= '0;
         bin <= '0;
         fd_prop <= 1'b0;
         bk_prop <= 1'b0;
         result_valid <= 1'b0;
         result_out <= '0;
         result_errors <= '0;
         osc_cnt <= '0;
         oscillator <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (state == IDLE && sample_valid) begin
            fin <= sample_x;
            target <= sample_target;
         end
         if (state == CAPTURE) begin
            result_out <= fout;
            err <= err_c;
            result_errors <= pc;
         end
         fd_prop <= state_n == FWD;
         bk_prop <= state_n == BWD;
         bin <= state_n == BWD ? (state == CAPTURE ? err_c : err) : '0;
         result_valid <= state_n == DONE;
         osc_cnt <= osc_cnt == OW'(OSC_HALF - 1) ? '0 : osc_cnt + OW'(1);
         oscillator <= osc_cnt == OW'(OSC_HALF - 1) ? !oscillator : oscillator;
      end
   end
endmodule

// File: tb/tb_fc_trainer.sv
// tb_fc_trainer: directed checks of the fc_trainer sequencing, error capture, backpressure and reset behaviour
module tb_fc_trainer;
   localparam int N = 9;
   localparam int FD = 4;
   localparam int BK = 3;
   logic clk_in = 1'b0;
   logic rst_in, sample_valid, result_ready;
   logic [N-1:0] sample_x, sample_target, fout;
   logic sample_ready, fd_prop, bk_prop, oscillator, result_valid;
   logic [N-1:0] fin, bin, result_out;
   logic [3:0] result_errors;
   int vectors = 0;
   int errs = 0;
   fc_trainer #(.N(N), .FD_CYCLES(FD), .BK_CYCLES(BK), .OSC_HALF(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_x(sample_x), .sample_target(sample_target), .fd_prop(fd_prop), .bk_prop(bk_prop),
      .fin(fin), .bin(bin), .fout(fout), .oscillator(oscillator), .result_valid(result_valid),
      .result_ready(result_ready), .result_out(result_out), .result_errors(result_errors)
   );
   always #5 clk_in = ~clk_in;
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask
   task automatic run_sample(input bit pre, input logic [N-1:0] x, input logic [N-1:0] t, input logic [N-1:0] f,
                             input int exp_lat, input int exp_bk, input logic [N-1:0] exp_bin, input int exp_cnt);
      int fdc, bkc, lat;
      fdc = 0;
      bkc = 0;
      lat = 0;
      fout = f;
      if (!pre) begin
         sample_x = x;
         sample_target = t;
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
      end
      for (int n = 0; n < 40; n++) begin
         if (n > 0) tick();
         if (fd_prop && bk_prop) chk("fd_bk_overlap", 1, 0);
         if (fd_prop) fdc++;
         if (bk_prop) begin
            bkc++;
            if (bin !== exp_bin) chk("bin_bwd", bin, exp_bin);
         end else if (bin !== '0) chk("bin_idle", bin, 0);
         if (result_valid) begin
            lat = n + 1;
            break;
         end
      end
      chk("latency", lat, exp_lat);
      chk("fd_cycles", fdc, FD);
      chk("bk_cycles", bkc, exp_bk);
      chk("fin", fin, x);
      chk("result_out", result_out, f);
      chk("result_errors", result_errors, exp_cnt);
      chk("ready_busy", sample_ready, 0);
   endtask
   task automatic release_result();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("valid_fall", result_valid, 0);
      chk("ready_rise", sample_ready, 1);
   endtask
   initial begin
      logic [N-1:0] hold_out;
      int rv;
      rst_in = 1'b1;
      sample_valid = 1'b0;
      result_ready = 1'b0;
      sample_x = '0;
      sample_target = '0;
      fout = '0;
      repeat (3) tick();
      chk("rst_fd", fd_prop, 0);
      chk("rst_bk", bk_prop, 0);
      chk("rst_fin", fin, 0);
      chk("rst_bin", bin, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_out", result_out, 0);
      chk("rst_errs", result_errors, 0);
      chk("rst_osc", oscillator, 0);
      chk("rst_ready", sample_ready, 0);
      rst_in = 1'b0;
      #1;
      chk("ready_after_rst", sample_ready, 1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("osc_%0d", i), oscillator, (i / 2) % 2);
      end
      run_sample(0, 9'b111000111, 9'b000111000, 9'b101010101, 9, BK, 9'b101101101, 6);
      release_result();
      run_sample(0, 9'b010101010, 9'b000111000, 9'b000111000, 6, 0, 9'b0, 0);
      release_result();
      run_sample(0, 9'b110011001, 9'b000000000, 9'b111111111, 9, BK, 9'b111111111, 9);
      release_result();
      run_sample(0, 9'b000011110, 9'b000000001, 9'b000000011, 9, BK, 9'b000000010, 1);
      hold_out = result_out;
      sample_x = 9'b100000001;
      sample_target = 9'b100000001;
      sample_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0 || i == 9) begin
            chk("bp_valid", result_valid, 1);
            chk("bp_ready", sample_ready, 0);
            chk("bp_out", result_out, hold_out);
            chk("bp_errs", result_errors, 1);
            chk("bp_fin", fin, 9'b000011110);
         end
      end
      release_result();
      tick();
      sample_valid = 1'b0;
      chk("bp_accept_fin", fin, 9'b100000001);
      chk("bp_accept_fd", fd_prop, 1);
      run_sample(1, 9'b100000001, 9'b100000001, 9'b100000001, 6, 0, 9'b0, 0);
      release_result();
      sample_x = 9'b111111111;
      sample_target = 9'b0;
      fout = 9'b111111111;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
      chk("mid_fd_second", fd_prop, 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("mid_fd_off", fd_prop, 0);
      chk("mid_bk_off", bk_prop, 0);
      chk("mid_fin", fin, 0);
      rv = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (result_valid || fd_prop) rv++;
      end
      chk("mid_no_result", rv, 0);
      run_sample(0, 9'b101000101, 9'b000000000, 9'b111111111, 9, BK, 9'b111111111, 9);
      release_result();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/fc_trainer.md
# fc_trainer

Sequencer that drives one `fc` bitnet layer through a full training step: it accepts an (input, target) sample, runs forward propagation, compares the layer output against the target, and runs backward propagation with the per-bit error vector. It sits between the sample source and the layer, and owns the `fin`, `bin`, `fd_prop`, `bk_prop` and `oscillator` signals the layer consumes. It reports the captured output and the mismatch count per sample.

## Interface
- `N`, 9, layer width in bits.
- `FD_CYCLES`, 100, clock cycles `fd_prop` is held high; must be ≥1.
- `BK_CYCLES`, 100, clock cycles `bk_prop` is held high; must be ≥1.
- `OSC_HALF`, 2, clock cycles per `oscillator` half-period; must be ≥1.
- `clk_in`  in  1  single clock; all logic is on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `sample_valid`  in  1  sample offered.
- `sample_ready`  out  1  trainer can accept a sample.
- `sample_x`  in  N  layer input for this sample.
- `sample_target`  in  N  desired layer output.
- `fd_prop`  out  1  forward-propagate enable to the layer.
- `bk_prop`  out  1  backward-propagate enable to the layer.
- `fin`  out  N  layer forward input.
- `bin`  out  N  layer backward input (error vector).
- `fout`  in  N  layer forward output.
- `oscillator`  out  1  free-running square wave to the layer.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  result consumer accepts.
- `result_out`  out  N  captured `fout`.
- `result_errors`  out  $clog2(N+1)  popcount of the error vector.

## Operation
- FSM states: IDLE, FWD, CAPTURE, BWD, DONE. Reset enters IDLE.
- IDLE:
  - `sample_ready`=1.
  - On `sample_valid && sample_ready`, register `sample_x` into `fin` and `sample_target` into the target register.
  - Load the counter with FD_CYCLES-1 and go to FWD.
- FWD:
  - `fd_prop`=1.
  - Decrement the counter each cycle. At 0, go to CAPTURE.
- CAPTURE (one cycle):
  - `fd_prop`=0, `bk_prop`=0.
  - At the end of the cycle, register `fout` into `result_out`, `err = fout ^ target` into the error register, and popcount(err) into `result_errors`.
  - If popcount is 0, go to DONE. Otherwise load the counter with BK_CYCLES-1 and go to BWD.
- BWD:
  - `bk_prop`=1 and `bin`=err register.
  - Decrement the counter. At 0, go to DONE.
- DONE:
  - `result_valid`=1; `result_out` and `result_errors` are held stable.
  - On `result_ready`, return to IDLE.
- `bin` is 0 in every state except BWD.
- `fin` holds its value from acceptance until the next acceptance.
- `fd_prop` and `bk_prop` are never high together. Both are registered, so they have no glitches.
- `sample_ready` = (state==IDLE). No sample is accepted in any other state; `sample_valid` is ignored outside IDLE.
- `oscillator`:
  - Driven by an independent counter that toggles it every OSC_HALF clocks.
  - Runs in all FSM states and is unaffected by the handshakes.
- Counter width is $clog2(max(FD_CYCLES,BK_CYCLES)+1). Popcount is computed with a full-width sum, so there is no overflow at an all-ones error vector (value N).

## Timing
- Reset values: state IDLE. `fd_prop`, `bk_prop`, `fin`, `bin`, `result_valid`, `result_out`, `result_errors`, `oscillator` and the oscillator counter are all 0.
- `sample_ready` is 0 during the reset cycle and 1 from the first cycle after reset deasserts.
- Sample accepted at edge k:
  - `fd_prop` is high for cycles k+1 … k+FD_CYCLES.
  - CAPTURE occupies cycle k+FD_CYCLES+1.
  - `bk_prop` is high for cycles k+FD_CYCLES+2 … k+FD_CYCLES+BK_CYCLES+1.
  - `result_valid` rises at cycle k+FD_CYCLES+BK_CYCLES+2.
- Zero error: `result_valid` rises at k+FD_CYCLES+2 and `bk_prop` never asserts.
- `result_valid && result_ready` at edge j: `result_valid` falls and `sample_ready` rises at j+1. A new sample can be accepted at edge j+1. Minimum sample period is FD_CYCLES+BK_CYCLES+3.
- `fout` is sampled only at the CAPTURE edge. The layer must have settled by FD_CYCLES.
- Reset mid-operation (any state):
  - At the reset edge, all registers return to reset values.
  - `fd_prop` and `bk_prop` are 0 from the next cycle.
  - The in-flight sample and result are discarded.
- `oscillator` period = 2·OSC_HALF clocks. The first toggle occurs OSC_HALF cycles after reset deasserts.

## Test plan
- Reset: hold `rst_in` 3 cycles. Every output is 0; after release, `sample_ready`=1 and `oscillator` toggles at cycles 2, 4, 6 (OSC_HALF=2).
- Basic step (N=9, FD=4, BK=3):
  - Stimulus: x=111000111, target=000111000, stub `fout`=101010101.
  - Expected: `fin`=111000111, `fd_prop` high for exactly 4 cycles.
  - Expected: `bk_prop` high for exactly 3 cycles with `bin`=101101101.
  - Expected: `result_out`=101010101, `result_errors`=6, `result_valid` at k+9.
- Zero error: stub `fout`=target=000111000 → `bk_prop` never high, `result_errors`=0, `result_valid` at k+6.
- All-mismatch: `fout`=111111111, target=000000000 → `bin`=111111111 during BWD, `result_errors`=9.
- Backpressure: hold `result_ready`=0 for 10 cycles in DONE while `sample_valid`=1 with new data. Result stays stable, `sample_ready`=0, and no sample is accepted. The first `result_ready` pulse returns to IDLE and the new sample is accepted one cycle later.
- Reset mid-FWD: assert `rst_in` on the 2nd `fd_prop` cycle → `fd_prop`=0 the next cycle, `result_valid` never rises, and a subsequent sample completes normally.
